// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder on the core fetch interface.
// Accepts one fetch per valid/ready handshake and returns one instruction after
// WAIT_STATES idle cycles. A word-write load port fills the array.
// Ports: clk, rst (async active-high); req_valid/req_ready/req_addr (fetch request);
// rsp_valid/rsp_ready/rsp_data/rsp_compressed/rsp_err (response);
// ld_we/ld_idx/ld_data (load port word write).
// Macro IMEM_COMPRESSED_EN: halfword fetches, split assembly and compressed detection;
// when undefined only word-aligned fetches are legal and full words are returned.
module imem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_compressed,
  output logic             rsp_err,
  input  logic             ld_we,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [31:0]      ld_data
);
`ifdef IMEM_COMPRESSED_EN
  typedef enum logic [2:0] {IDLE, WAIT, FETCH, FETCH2, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT, FETCH, RESP} state_t;
`endif
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [31:0] word;
  logic bad_addr;
  assign req_ready = state == IDLE;
  assign word = mem[idx];
`ifdef IMEM_COMPRESSED_EN
  logic half;
  logic [15:0] h;
  logic [15:0] sel;
  logic [15:0] next_lo;
  assign sel = half ? word[31:16] : word[15:0];
  assign next_lo = mem[idx + IDX_W'(1)][15:0];
  assign bad_addr = req_addr[0] || req_addr[31:2] >= DEPTH_W;
`else
  assign bad_addr = req_addr[1:0] != 2'b00 || req_addr[31:2] >= DEPTH_W;
`endif
  // Array is never reset; out-of-range load indices are dropped.
  always_ff @(posedge clk)
    if (ld_we && ld_idx <= LAST) mem[ld_idx] <= ld_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_compressed <= 1'b0;
      rsp_err <= 1'b0;
`ifdef IMEM_COMPRESSED_EN
      half <= 1'b0;
      h <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          idx <= req_addr[IDX_W+1:2];
`ifdef IMEM_COMPRESSED_EN
          half <= req_addr[1];
`endif
          // Faulting addresses skip the wait states and respond immediately.
          if (bad_addr) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_data <= '0;
            rsp_compressed <= 1'b0;
          end else state <= WAIT_STATES > 0 ? WAIT : FETCH;
        end
        WAIT: if (cnt == 4'(WAIT_STATES - 1)) begin
          cnt <= '0;
          state <= FETCH;
        end else cnt <= cnt + 4'd1;
        FETCH: begin
`ifdef IMEM_COMPRESSED_EN
          // Upper halfword starting a 32-bit instruction needs the next word.
          if (half && sel[1:0] == 2'b11) begin
            h <= sel;
            state <= FETCH2;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            rsp_compressed <= sel[1:0] != 2'b11;
            rsp_data <= sel[1:0] != 2'b11 ? {16'h0, sel} : word;
          end
`else
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_compressed <= 1'b0;
          rsp_data <= word;
`endif
        end
`ifdef IMEM_COMPRESSED_EN
        FETCH2: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_compressed <= 1'b0;
          rsp_err <= idx == LAST;
          rsp_data <= idx == LAST ? '0 : {next_lo, h};
        end
`endif
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  localparam int DEPTH = 48;
  localparam int IDX_W = $clog2(DEPTH);
  typedef struct packed {
    logic        err;
    logic        comp;
    logic [31:0] data;
    int          lat;
  } exp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, rsp_ready = 0, ld_we = 0, sel = 0;
  logic [31:0] req_addr = '0, ld_data = '0;
  logic [IDX_W-1:0] ld_idx = '0;
  logic rdy0, rdy1, rv0, rv1, comp0, comp1, err0, err1;
  logic [31:0] rd0, rd1;
  logic rdy, rv, comp, err;
  logic [31:0] rd;
  logic [31:0] sh [DEPTH];
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0), .req_addr(req_addr),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_compressed(comp0), .rsp_err(err0),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data));
  imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1), .req_addr(req_addr),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_compressed(comp1), .rsp_err(err1),
    .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data));
  assign rdy = sel ? rdy1 : rdy0;
  assign rv = sel ? rv1 : rv0;
  assign rd = sel ? rd1 : rd0;
  assign comp = sel ? comp1 : comp0;
  assign err = sel ? err1 : err0;
  function automatic exp_t model(input logic [31:0] a, input int ws);
    exp_t e;
    int i;
    logic [31:0] w;
    logic [15:0] hh;
    e = '0;
    i = int'(a[31:2]);
`ifdef IMEM_COMPRESSED_EN
    if (a[0] || i >= DEPTH) begin
      e.err = 1; e.lat = 1;
    end else begin
      w = sh[i];
      hh = a[1] ? w[31:16] : w[15:0];
      if (hh[1:0] != 2'b11) begin
        e.comp = 1; e.data = {16'h0, hh}; e.lat = 2 + ws;
      end else if (!a[1]) begin
        e.data = w; e.lat = 2 + ws;
      end else if (i + 1 >= DEPTH) begin
        e.err = 1; e.lat = 3 + ws;
      end else begin
        w = sh[i + 1];
        e.data = {w[15:0], hh}; e.lat = 3 + ws;
      end
    end
`else
    if (a[1:0] != 2'b00 || i >= DEPTH) begin
      e.err = 1; e.lat = 1;
    end else begin
      e.data = sh[i]; e.lat = 2 + ws;
    end
`endif
    return e;
  endfunction
  task automatic ld(input int i, input logic [31:0] d);
    @(negedge clk);
    ld_we = 1; ld_idx = IDX_W'(i); ld_data = d;
    @(negedge clk);
    ld_we = 0;
    if (i < DEPTH) sh[i] = d;
  endtask
  // Issue one fetch; optional concurrent load-port write lands on the FETCH edge (WAIT_STATES=0 only).
  task automatic fetch(input string nm, input logic [31:0] a, input int hold, input bit wr, input logic [31:0] wd);
    exp_t e;
    int lat, n;
    q.push_back(model(a, sel ? 3 : 0));
    @(negedge clk);
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_addr = a; rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    if (wr) begin ld_we = 1; ld_idx = IDX_W'(a[31:2]); ld_data = wd; end
    lat = 1;
    while (!rv && lat < 40) begin
      @(posedge clk); #1;
      ld_we = 0;
      lat++;
    end
    ld_we = 0;
    if (wr) sh[a[31:2]] = wd;
    e = q.pop_front();
    checks++;
    if (!rv) begin
      errors++; $display("FAIL %s timeout: rsp_valid never rose", nm);
      return;
    end
    checks += 4;
    if (rd !== e.data) begin errors++; $display("FAIL %s data: got %h want %h", nm, rd, e.data); end
    if (err !== e.err) begin errors++; $display("FAIL %s err: got %b want %b", nm, err, e.err); end
    if (comp !== e.comp) begin errors++; $display("FAIL %s comp: got %b want %b", nm, comp, e.comp); end
    if (lat != e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, lat, e.lat); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rv !== 1 || rd !== e.data || err !== e.err || rdy !== 0)
        begin errors++; $display("FAIL %s hold%0d: rv=%b data=%h err=%b rdy=%b want 1/%h/%b/0", nm, k, rv, rd, err, rdy, e.data, e.err); end
    end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL %s ready in RESP: got %b want 0", nm, rdy); end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    checks++;
    if (rv !== 0 || rdy !== 1) begin errors++; $display("FAIL %s after handshake: rv=%b rdy=%b want 0/1", nm, rv, rdy); end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (rv0 !== 0 || rd0 !== 0 || comp0 !== 0 || err0 !== 0 || rdy0 !== 1)
      begin errors++; $display("FAIL reset: rv=%b data=%h comp=%b err=%b rdy=%b want 0/0/0/0/1", rv0, rd0, comp0, err0, rdy0); end
    @(negedge clk); rst = 0;
  endtask
  task automatic test_single;
    sel = 0;
    ld(0, 32'h0050_0093);
    fetch("word0", 32'h0, 0, 0, 0);
  endtask
  task automatic test_compressed;
    sel = 0;
    ld(1, 32'h00B5_4501);
    fetch("lo_half", 32'h4, 0, 0, 0);
    fetch("hi_half", 32'h6, 0, 0, 0);
    fetch("addr2", 32'h2, 0, 0, 0);
    ld(1, 32'h0093_4501);
    ld(2, 32'hABCD_0013);
    fetch("split", 32'h6, 1, 0, 0);
  endtask
  task automatic test_errors;
    sel = 0;
    ld(47, 32'h0013_0001);
    fetch("misalign", 32'h3, 0, 0, 0);
    fetch("oob", 32'(4 * DEPTH), 0, 0, 0);
    fetch("split_oob", 32'(4 * DEPTH - 2), 0, 0, 0);
    fetch("last_lo", 32'(4 * DEPTH - 4), 0, 0, 0);
    ld(50, 32'hFFFF_FFFF);
    fetch("ld_ignored", 32'h8, 0, 0, 0);
  endtask
  task automatic test_wait;
    sel = 1;
    fetch("wait_hold", 32'h0, 5, 0, 0);
    fetch("wait_split", 32'h6, 0, 0, 0);
    sel = 0;
  endtask
  task automatic test_reset_mid;
    sel = 1;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rv !== 0 || rdy !== 1) begin errors++; $display("FAIL reset_mid%0d: rv=%b rdy=%b want 0/1", k, rv, rdy); end
    end
    fetch("after_reset", 32'h0, 0, 0, 0);
    sel = 0;
  endtask
  task automatic test_same_cycle_write;
    sel = 0;
    ld(3, 32'h1111_1113);
    fetch("wr_old", 32'hC, 0, 1, 32'h2222_2223);
    fetch("wr_new", 32'hC, 0, 0, 0);
  endtask
  task automatic test_back_to_back;
    sel = 0;
    fetch("b2b_a", 32'h0, 0, 0, 0);
    fetch("b2b_b", 32'h4, 0, 0, 0);
    fetch("b2b_c", 32'h8, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_single;
    test_compressed;
    test_errors;
    test_wait;
    test_reset_mid;
    test_same_cycle_write;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
